// File: rtl/motor_speed_ramp.sv
// Soft-start duty slew controller for the PWM/H-bridge stage: ramps duty toward the commanded value,
// and drains plus holds a dead time before any direction reversal. Optional brake input under SPEED_RAMP_BRAKE_EN.
module motor_speed_ramp #(
   parameter int RAMP_DIV   = 100000,
   parameter int STEP       = 1,
   parameter int DUTY_MAX   = 100,
   parameter int DEAD_TICKS = 4
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_duty,
   input  logic       cmd_dir,
   output logic [7:0] duty,
   output logic       dir,
   output logic       busy,
   output logic       at_target
`ifdef SPEED_RAMP_BRAKE_EN
  ,input  logic       brake
`endif
);

   localparam int         CW    = $clog2(RAMP_DIV);
   localparam int         DW    = $clog2(DEAD_TICKS + 1);
   localparam logic [8:0] STEP9 = 9'(STEP);

   typedef enum logic [1:0] {IDLE, RAMP, DRAIN, DEAD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] tick_cnt;
   logic          tick;
   logic [7:0]    target, target_nxt, duty_nxt, cmd_tgt;
   logic          dir_nxt, pend_dir, pend_dir_nxt, at_target_nxt;
   logic [DW-1:0] dead_cnt, dead_cnt_nxt;
   logic          accept, brake_act;

   // One STEP toward tgt without overshoot; 9-bit math keeps 255+STEP and 0-STEP safe.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] c9;
      logic [8:0] t9;
      c9 = {1'b0, cur};
      t9 = {1'b0, tgt};
      if (c9 < t9)
         return (c9 + STEP9 >= t9) ? tgt : 8'(c9 + STEP9);
      else if (c9 > t9)
         return (c9 >= t9 + STEP9) ? 8'(c9 - STEP9) : tgt;
      else
         return cur;
   endfunction

`ifdef SPEED_RAMP_BRAKE_EN
   assign brake_act = brake;
`else
   assign brake_act = 1'b0;
`endif

   assign tick    = (tick_cnt == CW'(RAMP_DIV - 1));
   assign accept  = cmd_valid & cmd_ready;
   assign cmd_tgt = (cmd_duty > 8'(DUTY_MAX)) ? 8'(DUTY_MAX) : cmd_duty;

   always_ff @(posedge clk_in) begin
      if (rst || tick) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + CW'(1);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= IDLE;
         duty      <= '0;
         dir       <= 1'b0;
         target    <= '0;
         pend_dir  <= 1'b0;
         dead_cnt  <= '0;
         at_target <= 1'b0;
      end else begin
         state     <= state_nxt;
         duty      <= duty_nxt;
         dir       <= dir_nxt;
         target    <= target_nxt;
         pend_dir  <= pend_dir_nxt;
         dead_cnt  <= dead_cnt_nxt;
         at_target <= at_target_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      duty_nxt      = duty;
      dir_nxt       = dir;
      target_nxt    = target;
      pend_dir_nxt  = pend_dir;
      dead_cnt_nxt  = dead_cnt;
      at_target_nxt = 1'b0;
      case (state)
         IDLE, RAMP: begin
            // A tick coinciding with an accept still steps toward the old target.
            if (state == RAMP && tick) duty_nxt = step_toward(duty, target);
            if (accept) begin
               target_nxt = cmd_tgt;
               if (cmd_dir != dir && duty != 8'd0) begin
                  pend_dir_nxt = cmd_dir;
                  state_nxt    = DRAIN;
               end else begin
                  dir_nxt = cmd_dir;
                  if (cmd_tgt != duty_nxt) begin
                     state_nxt = RAMP;
                  end else begin
                     state_nxt     = IDLE;
                     at_target_nxt = (state == RAMP);
                  end
               end
            end else if (state == RAMP && duty_nxt == target) begin
               state_nxt     = IDLE;
               at_target_nxt = 1'b1;
            end
         end
         DRAIN: begin
            if (tick) begin
               duty_nxt = step_toward(duty, 8'd0);
               if (duty_nxt == 8'd0) begin
                  state_nxt    = DEAD;
                  dead_cnt_nxt = '0;
               end
            end
         end
         DEAD: begin
            if (tick) begin
               if (dead_cnt == DW'(DEAD_TICKS - 1)) begin
                  dir_nxt = pend_dir;
                  if (target == 8'd0) begin
                     state_nxt     = IDLE;
                     at_target_nxt = 1'b1;
                  end else begin
                     state_nxt = RAMP;
                  end
               end else begin
                  dead_cnt_nxt = dead_cnt + DW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Emergency stop overrides everything except direction, which is held.
      if (brake_act) begin
         state_nxt     = IDLE;
         duty_nxt      = '0;
         dir_nxt       = dir;
         target_nxt    = '0;
         dead_cnt_nxt  = '0;
         at_target_nxt = 1'b0;
      end
   end

   always_comb begin
      busy      = (state != IDLE);
      cmd_ready = !rst && !brake_act && (state == IDLE || state == RAMP);
   end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Directed bench for motor_speed_ramp with RAMP_DIV=4, STEP=10, DUTY_MAX=100, DEAD_TICKS=2.
// Brake scenario is included when SPEED_RAMP_BRAKE_EN is defined.
module tb_motor_speed_ramp;
   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_duty = 8'd0;
   logic       cmd_dir = 1'b0;
   logic [7:0] duty;
   logic       dir;
   logic       busy;
   logic       at_target;
`ifdef SPEED_RAMP_BRAKE_EN
   logic       brake = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   motor_speed_ramp #(.RAMP_DIV(4), .STEP(10), .DUTY_MAX(100), .DEAD_TICKS(2)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_duty  (cmd_duty),
      .cmd_dir   (cmd_dir),
      .duty      (duty),
      .dir       (dir),
      .busy      (busy),
      .at_target (at_target)
`ifdef SPEED_RAMP_BRAKE_EN
     ,.brake     (brake)
`endif
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Waits (bounded) for the next duty change and checks its value.
   task automatic wait_duty(input string tag, input logic [7:0] exp, output int gap);
      logic [7:0] prev;
      prev = duty;
      gap = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_in);
         gap++;
         if (duty !== prev) break;
      end
      chk(tag, duty, exp);
   endtask

   task automatic send(input logic [7:0] d, input logic dr);
      cmd_valid = 1'b1;
      cmd_duty  = d;
      cmd_dir   = dr;
      for (int i = 0; i < 40 && cmd_ready !== 1'b1; i++) @(negedge clk_in);
      @(negedge clk_in);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int gap;
      // Reset held three cycles
      repeat (3) @(negedge clk_in);
      chk("rst_duty", duty, 0);
      chk("rst_dir", dir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_at_target", at_target, 0);
      rst = 1'b0;
      @(negedge clk_in);
      chk("ready_after_rst", cmd_ready, 1);

      // 0 -> 50, same direction
      send(8'd50, 1'b0);
      chk("busy_ramp50", busy, 1);
      for (int v = 10; v <= 50; v += 10) begin
         wait_duty("ramp50", 8'(v), gap);
         if (v > 10) chk("gap50", gap, 4);
      end
      chk("at_target50", at_target, 1);
      chk("busy_fall50", busy, 0);
      @(negedge clk_in);
      chk("at_target50_pulse", at_target, 0);

      // Clamp 255 -> 100, then down to 55 with a partial last step
      send(8'd255, 1'b0);
      for (int v = 60; v <= 100; v += 10) wait_duty("ramp_clamp", 8'(v), gap);
      chk("at_target100", at_target, 1);
      send(8'd55, 1'b0);
      for (int v = 90; v >= 60; v -= 10) wait_duty("ramp_down", 8'(v), gap);
      wait_duty("ramp_down55", 8'd55, gap);
      chk("at_target55", at_target, 1);
      send(8'd50, 1'b0);
      wait_duty("ramp_to50", 8'd50, gap);

      // Reversal 50/dir0 -> 30/dir1
      send(8'd30, 1'b1);
      chk("rev_ready", cmd_ready, 0);
      chk("rev_busy", busy, 1);
      for (int v = 40; v >= 0; v -= 10) begin
         wait_duty("drain", 8'(v), gap);
         chk("drain_dir", dir, 0);
      end
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         gap++;
         if (dir !== 1'b0) break;
      end
      chk("dead_cycles", gap, 8);
      chk("dead_dir", dir, 1);
      chk("dead_duty", duty, 0);
      for (int v = 10; v <= 30; v += 10) wait_duty("rev_ramp", 8'(v), gap);
      chk("rev_at_target", at_target, 1);
      chk("rev_busy_fall", busy, 0);

      // Reversal with a command held while not ready
      send(8'd40, 1'b0);
      cmd_valid = 1'b1;
      cmd_duty  = 8'd70;
      cmd_dir   = 1'b0;
      chk("hold_ready0", cmd_ready, 0);
      wait_duty("hold_drain20", 8'd20, gap);
      chk("hold_ready1", cmd_ready, 0);
      wait_duty("hold_drain10", 8'd10, gap);
      wait_duty("hold_drain0", 8'd0, gap);
      for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) @(negedge clk_in);
      chk("hold_ready_rise", cmd_ready, 1);
      chk("hold_dir", dir, 0);
      @(negedge clk_in);
      cmd_valid = 1'b0;
      for (int v = 10; v <= 70; v += 10) wait_duty("hold_ramp", 8'(v), gap);
      chk("hold_at_target", at_target, 1);

      // Retarget while ramping toward 80
      send(8'd30, 1'b0);
      for (int v = 60; v >= 30; v -= 10) wait_duty("down30", 8'(v), gap);
      send(8'd80, 1'b0);
      wait_duty("up40", 8'd40, gap);
      send(8'd20, 1'b0);
      wait_duty("retgt30", 8'd30, gap);
      chk("retgt_busy", busy, 1);
      wait_duty("retgt20", 8'd20, gap);
      chk("retgt_at_target", at_target, 1);
      chk("retgt_idle", busy, 0);

      // Reset mid-operation, pending command discarded
      send(8'd0, 1'b0);
      wait_duty("zero10", 8'd10, gap);
      wait_duty("zero0", 8'd0, gap);
      send(8'd60, 1'b1);
      chk("dir_flip_at0", dir, 1);
      chk("dir_flip_busy", busy, 1);
      wait_duty("r10", 8'd10, gap);
      wait_duty("r20", 8'd20, gap);
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_duty  = 8'd90;
      @(negedge clk_in);
      chk("mid_rst_duty", duty, 0);
      chk("mid_rst_dir", dir, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", cmd_ready, 0);
      rst       = 1'b0;
      cmd_valid = 1'b0;
      repeat (6) @(negedge clk_in);
      chk("post_rst_duty", duty, 0);
      chk("post_rst_busy", busy, 0);

`ifdef SPEED_RAMP_BRAKE_EN
      // Brake at 60 while ramping toward 100
      send(8'd100, 1'b1);
      for (int v = 10; v <= 60; v += 10) wait_duty("brk_ramp", 8'(v), gap);
      brake = 1'b1;
      @(negedge clk_in);
      chk("brk_duty", duty, 0);
      chk("brk_busy", busy, 0);
      chk("brk_ready", cmd_ready, 0);
      chk("brk_dir", dir, 1);
      chk("brk_at_target", at_target, 0);
      brake = 1'b0;
      @(negedge clk_in);
      chk("brk_rel_ready", cmd_ready, 1);
      chk("brk_rel_busy", busy, 0);
      chk("brk_rel_duty", duty, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/motor_speed_ramp.md
# motor_speed_ramp

Soft-start speed controller sitting directly upstream of the motor PWM generator. It accepts speed commands (duty 0..100 plus direction) over a valid/ready handshake and slews its duty output toward the commanded value in fixed steps at a programmable tick rate. On a direction reversal it first drains duty to zero, holds a dead time, then flips direction and ramps up again. Its `duty` output drives the PWM mark/space ratio input; `dir` drives the H-bridge direction pins.

## Interface
- `RAMP_DIV`, 100000: clock cycles per ramp tick (≥2)
- `STEP`, 1: duty change per tick (1..DUTY_MAX)
- `DUTY_MAX`, 100: upper clamp on duty; matches the PWM period of 100 counts
- `DEAD_TICKS`, 4: ticks held at duty 0 before a direction flip (≥1)

- `clk_in`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block accepts command this cycle
- `cmd_duty`  in  8  requested duty, 0..255 (clamped)
- `cmd_dir`  in  1  requested direction
- `duty`  out  8  current duty to PWM, 0..DUTY_MAX
- `dir`  out  1  current direction
- `busy`  out  1  ramp/drain/dead in progress
- `at_target`  out  1  one-cycle pulse when a ramp completes
- `brake`  in  1  emergency stop (only with SPEED_RAMP_BRAKE_EN)

## Operation
- Reset: state IDLE, `duty`=0, `dir`=0, target=0, `busy`=0, `at_target`=0, tick counter=0; `cmd_ready`=0 while `rst` high.
- Tick: free-running counter 0..RAMP_DIV-1; `tick` asserted in the cycle it equals RAMP_DIV-1, then wraps to 0.
- Accept = `cmd_valid & cmd_ready`. Latched target = min(`cmd_duty`, DUTY_MAX).
- `cmd_ready` = 1 in IDLE and RAMP, 0 in DRAIN and DEAD.
- States:
  - IDLE: on accept with same dir, or with `duty`==0 (dir updated immediately on accept): target ≠ `duty` → RAMP, else stay. Accept with different dir and `duty`≠0 → DRAIN, pending dir stored.
  - RAMP: on tick, `duty` ← min(`duty`+STEP, target) if below, max(`duty`−STEP, target) if above; no wrap/underflow (compute in 9 bits). When `duty`==target → IDLE with `at_target` pulse. Accept in RAMP retargets (reversal rules as IDLE).
  - DRAIN: on tick, `duty` ← max(`duty`−STEP, 0); on reaching 0 → DEAD.
  - DEAD: count DEAD_TICKS ticks at `duty`=0; then `dir` ← pending dir, → RAMP (IDLE with `at_target` pulse if target 0).
- `busy` = state ≠ IDLE.
- Accept coinciding with tick: the step in that cycle uses the old target; new target takes effect next cycle.

## Timing
- All outputs registered; `duty` changes only in the cycle after a tick.
- First step after an accept from IDLE occurs on the next tick (0..RAMP_DIV-1 cycles later; counter not restarted).
- Full ramp 0→T with same dir: ceil(T/STEP) ticks.
- Reversal from duty D: ceil(D/STEP) ticks drain + DEAD_TICKS ticks dead + ramp-up ticks.
- `at_target` high exactly one cycle, same cycle `busy` falls.
- Reset mid-operation: next cycle all outputs at reset values; pending command discarded.

## Configuration
- `SPEED_RAMP_BRAKE_EN` defined: `brake` port exists; while high, `duty` forced to 0 next cycle, target cleared, state IDLE, `cmd_ready`=0, `dir` held, no `at_target` pulse; brake has priority over accept and tick.
- Undefined: no `brake` port; behaviour as above without it.

## Test plan
(RAMP_DIV=4, STEP=10, DUTY_MAX=100, DEAD_TICKS=2)
- Reset held 3 cycles → `duty`=0, `dir`=0, `busy`=0, `cmd_ready`=0; first cycle after release `cmd_ready`=1.
- Cmd 50/dir0 from IDLE → `duty` 10,20,30,40,50 one step per 4 cycles; `at_target` one pulse when 50 reached; `busy` falls same cycle.
- Cmd 255/dir0 → clamped, ends at 100; then cmd 55 → 90,80,70,60,55 (partial last step).
- At 50/dir0, cmd 30/dir1 → `cmd_ready`=0; duty 40,30,20,10,0 with `dir`=0; 2 ticks at 0; `dir`=1; 10,20,30; `at_target` pulse.
- Ramping toward 80, at 40 issue cmd 20/dir0 → next ticks 30,20, then IDLE; `cmd_valid` held with `cmd_ready`=0 during DRAIN is not consumed until ready.
- SPEED_RAMP_BRAKE_EN: at 60 ramping to 100, `brake`=1 → `duty`=0 next cycle, `busy`=0, `cmd_ready`=0, `dir` unchanged; release → IDLE, ready=1.
